// File: rtl/axi_reg_slice_pkg.sv
// ============================================================================
// Module      : axi_reg_slice_pkg
// Description : Payload widths and packed per-channel payload structs shared
//               by the AXI4 register slice and its skid buffers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi_reg_slice_pkg;

  localparam int AddressWidth = 20;
  localparam int DataWidth    = 64;
  localparam int StrbWidth    = DataWidth / 8;
  localparam int IdWidth      = 8;

  // Address channel payload, shared layout for AW and AR
  typedef struct packed {
    logic [IdWidth-1:0]      id;
    logic [AddressWidth-1:0] addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
    logic                    lock;
    logic [3:0]              cache;
    logic [2:0]              prot;
  } ax_chan_t;

  typedef ax_chan_t aw_chan_t;
  typedef ax_chan_t ar_chan_t;

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [StrbWidth-1:0] strb;
    logic                 last;
  } w_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic [1:0]         resp;
  } b_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [DataWidth-1:0] data;
    logic [1:0]           resp;
    logic                 last;
  } r_chan_t;

endpackage

`default_nettype wire

// File: rtl/axi_reg_slice_skid.sv
// ============================================================================
// Module      : axi_skid_buffer
// Description : Two-entry skid buffer (main + skid register). Registered
//               in_ready and out_valid/out_data, full throughput.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_skid_buffer #(
  parameter int PayloadWidth = 8
) (
  input  logic                    clk,
  input  logic                    areset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [PayloadWidth-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [PayloadWidth-1:0] out_data
);

  logic                    r_main_valid;
  logic                    r_skid_valid;
  logic                    r_in_ready;
  logic [PayloadWidth-1:0] r_main_data;
  logic [PayloadWidth-1:0] r_skid_data;

  logic w_in_acc;
  logic w_main_free;
  logic w_skid_valid_nxt;

  assign w_in_acc    = in_valid && r_in_ready;
  // Main may be (re)loaded when it is empty or its beat is leaving this cycle
  assign w_main_free = !r_main_valid || out_ready;

  // Skid fills only when a beat arrives while main is stuck; any free slot in
  // main drains it (in_ready is low whenever skid is full, so no new beat
  // competes with the skid->main move).
  always_comb begin
    w_skid_valid_nxt = r_skid_valid;
    if (w_main_free) begin
      w_skid_valid_nxt = 1'b0;
    end else if (w_in_acc) begin
      w_skid_valid_nxt = 1'b1;
    end
  end

  // Main/skid registers and the registered ready
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b0;
      r_main_data  <= '0;
      r_skid_data  <= '0;
    end else begin
      r_skid_valid <= w_skid_valid_nxt;
      r_in_ready   <= !w_skid_valid_nxt;
      if (w_main_free) begin
        if (r_skid_valid) begin
          r_main_valid <= 1'b1;
          r_main_data  <= r_skid_data;
        end else begin
          r_main_valid <= w_in_acc;
          if (w_in_acc) begin
            r_main_data <= in_data;
          end
        end
      end else if (w_in_acc) begin
        r_skid_data <= in_data;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_main_valid;
  assign out_data  = r_main_data;

endmodule

`default_nettype wire

// File: rtl/axi_reg_slice.sv
// ============================================================================
// Module      : axi_reg_slice
// Description : Full-throughput AXI4 register slice. Each of the five
//               channels passes through an independent skid buffer; this
//               level only packs/unpacks channel structs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_reg_slice
  import axi_reg_slice_pkg::*;
(
  input  logic                    clk,
  input  logic                    areset_n,
  // Manager side: write address
  input  logic [IdWidth-1:0]      s_awid,
  input  logic [AddressWidth-1:0] s_awaddr,
  input  logic [7:0]              s_awlen,
  input  logic [2:0]              s_awsize,
  input  logic [1:0]              s_awburst,
  input  logic                    s_awlock,
  input  logic [3:0]              s_awcache,
  input  logic [2:0]              s_awprot,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  // Manager side: write data
  input  logic [DataWidth-1:0]    s_wdata,
  input  logic [StrbWidth-1:0]    s_wstrb,
  input  logic                    s_wlast,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  // Manager side: write response
  output logic [IdWidth-1:0]      s_bid,
  output logic [1:0]              s_bresp,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  // Manager side: read address
  input  logic [IdWidth-1:0]      s_arid,
  input  logic [AddressWidth-1:0] s_araddr,
  input  logic [7:0]              s_arlen,
  input  logic [2:0]              s_arsize,
  input  logic [1:0]              s_arburst,
  input  logic                    s_arlock,
  input  logic [3:0]              s_arcache,
  input  logic [2:0]              s_arprot,
  input  logic                    s_arvalid,
  output logic                    s_arready,
  // Manager side: read data
  output logic [IdWidth-1:0]      s_rid,
  output logic [DataWidth-1:0]    s_rdata,
  output logic [1:0]              s_rresp,
  output logic                    s_rlast,
  output logic                    s_rvalid,
  input  logic                    s_rready,
  // Subordinate side: write address
  output logic [IdWidth-1:0]      m_awid,
  output logic [AddressWidth-1:0] m_awaddr,
  output logic [7:0]              m_awlen,
  output logic [2:0]              m_awsize,
  output logic [1:0]              m_awburst,
  output logic                    m_awlock,
  output logic [3:0]              m_awcache,
  output logic [2:0]              m_awprot,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  // Subordinate side: write data
  output logic [DataWidth-1:0]    m_wdata,
  output logic [StrbWidth-1:0]    m_wstrb,
  output logic                    m_wlast,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  // Subordinate side: write response
  input  logic [IdWidth-1:0]      m_bid,
  input  logic [1:0]              m_bresp,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  // Subordinate side: read address
  output logic [IdWidth-1:0]      m_arid,
  output logic [AddressWidth-1:0] m_araddr,
  output logic [7:0]              m_arlen,
  output logic [2:0]              m_arsize,
  output logic [1:0]              m_arburst,
  output logic                    m_arlock,
  output logic [3:0]              m_arcache,
  output logic [2:0]              m_arprot,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  // Subordinate side: read data
  input  logic [IdWidth-1:0]      m_rid,
  input  logic [DataWidth-1:0]    m_rdata,
  input  logic [1:0]              m_rresp,
  input  logic                    m_rlast,
  input  logic                    m_rvalid,
  output logic                    m_rready
);

  aw_chan_t w_aw_in, w_aw_out;
  w_chan_t  w_w_in,  w_w_out;
  b_chan_t  w_b_in,  w_b_out;
  ar_chan_t w_ar_in, w_ar_out;
  r_chan_t  w_r_in,  w_r_out;

  assign w_aw_in = '{id: s_awid, addr: s_awaddr, len: s_awlen, size: s_awsize,
                     burst: s_awburst, lock: s_awlock, cache: s_awcache, prot: s_awprot};
  assign w_w_in  = '{data: s_wdata, strb: s_wstrb, last: s_wlast};
  assign w_b_in  = '{id: m_bid, resp: m_bresp};
  assign w_ar_in = '{id: s_arid, addr: s_araddr, len: s_arlen, size: s_arsize,
                     burst: s_arburst, lock: s_arlock, cache: s_arcache, prot: s_arprot};
  assign w_r_in  = '{id: m_rid, data: m_rdata, resp: m_rresp, last: m_rlast};

  axi_skid_buffer #(.PayloadWidth($bits(aw_chan_t))) u_aw (
    .clk(clk), .areset_n(areset_n),
    .in_valid(s_awvalid), .in_ready(s_awready), .in_data(w_aw_in),
    .out_valid(m_awvalid), .out_ready(m_awready), .out_data(w_aw_out)
  );

  axi_skid_buffer #(.PayloadWidth($bits(w_chan_t))) u_w (
    .clk(clk), .areset_n(areset_n),
    .in_valid(s_wvalid), .in_ready(s_wready), .in_data(w_w_in),
    .out_valid(m_wvalid), .out_ready(m_wready), .out_data(w_w_out)
  );

  axi_skid_buffer #(.PayloadWidth($bits(b_chan_t))) u_b (
    .clk(clk), .areset_n(areset_n),
    .in_valid(m_bvalid), .in_ready(m_bready), .in_data(w_b_in),
    .out_valid(s_bvalid), .out_ready(s_bready), .out_data(w_b_out)
  );

  axi_skid_buffer #(.PayloadWidth($bits(ar_chan_t))) u_ar (
    .clk(clk), .areset_n(areset_n),
    .in_valid(s_arvalid), .in_ready(s_arready), .in_data(w_ar_in),
    .out_valid(m_arvalid), .out_ready(m_arready), .out_data(w_ar_out)
  );

  axi_skid_buffer #(.PayloadWidth($bits(r_chan_t))) u_r (
    .clk(clk), .areset_n(areset_n),
    .in_valid(m_rvalid), .in_ready(m_rready), .in_data(w_r_in),
    .out_valid(s_rvalid), .out_ready(s_rready), .out_data(w_r_out)
  );

  assign m_awid    = w_aw_out.id;
  assign m_awaddr  = w_aw_out.addr;
  assign m_awlen   = w_aw_out.len;
  assign m_awsize  = w_aw_out.size;
  assign m_awburst = w_aw_out.burst;
  assign m_awlock  = w_aw_out.lock;
  assign m_awcache = w_aw_out.cache;
  assign m_awprot  = w_aw_out.prot;

  assign m_wdata   = w_w_out.data;
  assign m_wstrb   = w_w_out.strb;
  assign m_wlast   = w_w_out.last;

  assign s_bid     = w_b_out.id;
  assign s_bresp   = w_b_out.resp;

  assign m_arid    = w_ar_out.id;
  assign m_araddr  = w_ar_out.addr;
  assign m_arlen   = w_ar_out.len;
  assign m_arsize  = w_ar_out.size;
  assign m_arburst = w_ar_out.burst;
  assign m_arlock  = w_ar_out.lock;
  assign m_arcache = w_ar_out.cache;
  assign m_arprot  = w_ar_out.prot;

  assign s_rid     = w_r_out.id;
  assign s_rdata   = w_r_out.data;
  assign s_rresp   = w_r_out.resp;
  assign s_rlast   = w_r_out.last;

endmodule

`default_nettype wire

// File: tb/tb_axi_reg_slice.sv
// ============================================================================
// Module      : tb_axi_reg_slice
// Description : Self-checking bench for axi_reg_slice. Each channel is a
//               FIFO of at most two beats in the reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_reg_slice;
  import axi_reg_slice_pkg::*;

  typedef logic [127:0] beat_t;

  // Channel index: 0=AW 1=W 2=AR 3=B 4=R (input side -> output side)
  localparam int NCH = 5;
  int    cw [NCH] = '{$bits(aw_chan_t), $bits(w_chan_t), $bits(ar_chan_t),
                      $bits(b_chan_t), $bits(r_chan_t)};
  string nm [NCH] = '{"AW", "W", "AR", "B", "R"};

  logic clk = 1'b0;
  logic areset_n = 1'b0;
  always #5 clk = ~clk;

  logic [4:0]        iv, ordy;
  logic [4:0][127:0] idata;
  logic [4:0]        ov, irdy;
  logic [4:0][127:0] odata;

  aw_chan_t i_aw;
  w_chan_t  i_w;
  ar_chan_t i_ar;
  b_chan_t  i_b;
  r_chan_t  i_r;
  assign i_aw = idata[0][$bits(aw_chan_t)-1:0];
  assign i_w  = idata[1][$bits(w_chan_t)-1:0];
  assign i_ar = idata[2][$bits(ar_chan_t)-1:0];
  assign i_b  = idata[3][$bits(b_chan_t)-1:0];
  assign i_r  = idata[4][$bits(r_chan_t)-1:0];

  logic [7:0]  m_awid, m_arid, s_bid, s_rid;
  logic [19:0] m_awaddr, m_araddr;
  logic [7:0]  m_awlen, m_arlen;
  logic [2:0]  m_awsize, m_arsize, m_awprot, m_arprot;
  logic [1:0]  m_awburst, m_arburst, s_bresp, s_rresp;
  logic        m_awlock, m_arlock, m_wlast, s_rlast;
  logic [3:0]  m_awcache, m_arcache;
  logic [63:0] m_wdata, s_rdata;
  logic [7:0]  m_wstrb;

  assign odata[0] = 128'({m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awlock, m_awcache, m_awprot});
  assign odata[1] = 128'({m_wdata, m_wstrb, m_wlast});
  assign odata[2] = 128'({m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arlock, m_arcache, m_arprot});
  assign odata[3] = 128'({s_bid, s_bresp});
  assign odata[4] = 128'({s_rid, s_rdata, s_rresp, s_rlast});

  axi_reg_slice dut (
    .clk(clk), .areset_n(areset_n),
    .s_awid(i_aw.id), .s_awaddr(i_aw.addr), .s_awlen(i_aw.len), .s_awsize(i_aw.size),
    .s_awburst(i_aw.burst), .s_awlock(i_aw.lock), .s_awcache(i_aw.cache), .s_awprot(i_aw.prot),
    .s_awvalid(iv[0]), .s_awready(irdy[0]),
    .s_wdata(i_w.data), .s_wstrb(i_w.strb), .s_wlast(i_w.last),
    .s_wvalid(iv[1]), .s_wready(irdy[1]),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(ov[3]), .s_bready(ordy[3]),
    .s_arid(i_ar.id), .s_araddr(i_ar.addr), .s_arlen(i_ar.len), .s_arsize(i_ar.size),
    .s_arburst(i_ar.burst), .s_arlock(i_ar.lock), .s_arcache(i_ar.cache), .s_arprot(i_ar.prot),
    .s_arvalid(iv[2]), .s_arready(irdy[2]),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(ov[4]), .s_rready(ordy[4]),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awlock(m_awlock), .m_awcache(m_awcache), .m_awprot(m_awprot),
    .m_awvalid(ov[0]), .m_awready(ordy[0]),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wvalid(ov[1]), .m_wready(ordy[1]),
    .m_bid(i_b.id), .m_bresp(i_b.resp), .m_bvalid(iv[3]), .m_bready(irdy[3]),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arlock(m_arlock), .m_arcache(m_arcache), .m_arprot(m_arprot),
    .m_arvalid(ov[2]), .m_arready(ordy[2]),
    .m_rid(i_r.id), .m_rdata(i_r.data), .m_rresp(i_r.resp), .m_rlast(i_r.last),
    .m_rvalid(iv[4]), .m_rready(irdy[4])
  );

  // Reference model: per-channel FIFO of beats held inside the slice, plus
  // the beats each source still has to send.
  beat_t q   [NCH][$];
  beat_t src [NCH][$];
  int    vprob [NCH];
  int    rprob [NCH];     // 0..100 = percent ready, 101 = alternate 1/0
  logic [4:0] hold;
  logic  tog;
  int    acc_cnt [NCH];
  int    dlv_cnt [NCH];
  int    checks = 0;
  int    errors = 0;

  function automatic beat_t rnd_beat(int c);
    beat_t b;
    b = {$urandom, $urandom, $urandom, $urandom};
    return b & ((128'd1 << cw[c]) - 128'd1);
  endfunction

  task automatic set_all(int vp, int rp);
    for (int c = 0; c < NCH; c++) begin
      vprob[c] = vp;
      rprob[c] = rp;
    end
  endtask

  // One clock: check outputs against the model, then drive the next inputs
  // and advance the model by the handshakes that the coming edge performs.
  task automatic cycle();
    logic in_acc, out_acc;
    @(negedge clk);
    for (int c = 0; c < NCH; c++) begin
      checks++;
      if (ov[c] !== (q[c].size() > 0)) begin
        errors++;
        $display("FAIL %s valid: got %b want %b (t=%0t)", nm[c], ov[c], q[c].size() > 0, $time);
      end
      checks++;
      if (irdy[c] !== (q[c].size() < 2)) begin
        errors++;
        $display("FAIL %s ready: got %b want %b (t=%0t)", nm[c], irdy[c], q[c].size() < 2, $time);
      end
      if (q[c].size() > 0) begin
        checks++;
        if (odata[c] !== q[c][0]) begin
          errors++;
          $display("FAIL %s payload: got %h want %h (t=%0t)", nm[c], odata[c], q[c][0], $time);
        end
      end
    end
    tog = ~tog;
    for (int c = 0; c < NCH; c++) begin
      if (!hold[c]) begin
        if (src[c].size() > 0 && int'($urandom_range(99)) < vprob[c]) begin
          iv[c]    = 1'b1;
          idata[c] = src[c][0];
        end else begin
          iv[c]    = 1'b0;
          idata[c] = rnd_beat(c);
        end
      end
      ordy[c] = (rprob[c] > 100) ? tog : (int'($urandom_range(99)) < rprob[c]);
      in_acc  = iv[c] && (q[c].size() < 2);
      out_acc = (q[c].size() > 0) && ordy[c];
      hold[c] = iv[c] && !in_acc;
      if (out_acc) begin
        void'(q[c].pop_front());
        dlv_cnt[c]++;
      end
      if (in_acc) begin
        q[c].push_back(src[c].pop_front());
        acc_cnt[c]++;
      end
    end
  endtask

  task automatic drain(int budget, string tag);
    int n;
    bit busy;
    n = 0;
    busy = 1'b1;
    while (busy && n < budget) begin
      cycle();
      n++;
      busy = 1'b0;
      for (int c = 0; c < NCH; c++)
        if (src[c].size() > 0 || q[c].size() > 0 || hold[c]) busy = 1'b1;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL %s drain: got still busy after %0d cycles want empty", tag, budget);
    end
  endtask

  task automatic check_all_zero(string tag);
    for (int c = 0; c < NCH; c++) begin
      checks++;
      if (ov[c] !== 1'b0 || irdy[c] !== 1'b0 || odata[c] !== '0) begin
        errors++;
        $display("FAIL %s %s: got valid=%b ready=%b data=%h want all 0",
                 tag, nm[c], ov[c], irdy[c], odata[c]);
      end
    end
  endtask

  task automatic test_reset();
    iv = '0; ordy = '0; hold = '0; tog = 1'b0;
    for (int c = 0; c < NCH; c++) idata[c] = rnd_beat(c);
    areset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    areset_n = 1'b1;
    #1;
    for (int c = 0; c < NCH; c++) begin
      checks++;
      if (irdy[c] !== 1'b0) begin
        errors++;
        $display("FAIL release %s ready before edge: got %b want 0", nm[c], irdy[c]);
      end
    end
    set_all(0, 100);
    cycle();   // readies must be 1 after the first edge
  endtask

  task automatic test_single_write();
    aw_chan_t a;
    w_chan_t  w;
    b_chan_t  b;
    a = '0; a.id = 8'h5A; a.addr = 20'h00100; a.len = 8'd3; a.size = 3'd3; a.burst = 2'b01;
    src[0].push_back(128'(a));
    for (int i = 0; i < 4; i++) begin
      w.data = 64'(i + 1) * 64'h1111;
      w.strb = 8'hFF;
      w.last = (i == 3);
      src[1].push_back(128'(w));
    end
    b.id = 8'h5A; b.resp = 2'b00;
    src[3].push_back(128'(b));
    set_all(100, 100);
    drain(40, "single_write");
  endtask

  task automatic test_back_to_back();
    r_chan_t r;
    int first, last_i, seen;
    for (int i = 0; i < 8; i++) begin
      r.id = 8'h3C; r.data = {$urandom, $urandom}; r.resp = 2'b00; r.last = (i == 7);
      src[4].push_back(128'(r));
    end
    set_all(100, 100);
    first = -1; last_i = -1; seen = 0;
    for (int k = 0; k < 14; k++) begin
      cycle();
      if (ov[4]) begin
        if (first < 0) first = k;
        last_i = k;
        seen++;
      end
    end
    checks++;
    if (seen != 8 || (last_i - first + 1) != 8) begin
      errors++;
      $display("FAIL b2b rvalid cycles: got %0d over span %0d want 8 over 8", seen, last_i - first + 1);
    end
    drain(10, "back_to_back");
  endtask

  task automatic test_stall();
    w_chan_t w;
    int a0, d0;
    for (int i = 0; i < 4; i++) begin
      w.data = {$urandom, $urandom}; w.strb = 8'(i * 3 + 1); w.last = (i == 3);
      src[1].push_back(128'(w));
    end
    set_all(0, 100);
    vprob[1] = 100; rprob[1] = 0;
    a0 = acc_cnt[1]; d0 = dlv_cnt[1];
    repeat (6) cycle();
    checks++;
    if (acc_cnt[1] - a0 != 2 || irdy[1] !== 1'b0) begin
      errors++;
      $display("FAIL stall accepted: got %0d ready=%b want 2 ready=0", acc_cnt[1] - a0, irdy[1]);
    end
    rprob[1] = 100;
    drain(20, "stall");
    checks++;
    if (dlv_cnt[1] - d0 != 4) begin
      errors++;
      $display("FAIL stall delivered: got %0d want 4", dlv_cnt[1] - d0);
    end
  endtask

  task automatic test_toggle_ready();
    r_chan_t r;
    for (int i = 0; i < 4; i++) begin
      r.id = 8'h77; r.data = {$urandom, $urandom}; r.resp = 2'(i); r.last = (i == 3);
      src[4].push_back(128'(r));
    end
    set_all(100, 100);
    rprob[4] = 101;
    drain(30, "toggle_ready");
  endtask

  task automatic test_concurrent();
    aw_chan_t a;
    ar_chan_t ar;
    a = '0; a.id = 8'h11; a.addr = 20'h00200; a.len = 8'd3; a.burst = 2'b01;
    ar = '0; ar.id = 8'h22; ar.addr = 20'h00200; ar.len = 8'd3; ar.burst = 2'b01;
    src[0].push_back(128'(a));
    src[2].push_back(128'(ar));
    for (int i = 0; i < 4; i++) begin
      src[1].push_back(rnd_beat(1));
      src[4].push_back(rnd_beat(4));
    end
    src[3].push_back(rnd_beat(3));
    set_all(70, 70);
    drain(100, "concurrent");
  endtask

  task automatic test_random();
    for (int c = 0; c < NCH; c++)
      for (int i = 0; i < 40; i++) src[c].push_back(rnd_beat(c));
    set_all(60, 60);
    drain(2000, "random");
  endtask

  task automatic test_reset_mid();
    int a0, n;
    for (int i = 0; i < 4; i++) src[1].push_back(rnd_beat(1));
    src[0].push_back(rnd_beat(0));
    set_all(100, 100);
    rprob[1] = 0;   // keep W beats in flight inside the slice
    a0 = acc_cnt[1];
    n = 0;
    while (acc_cnt[1] - a0 < 2 && n < 20) begin
      cycle();
      n++;
    end
    checks++;
    if (acc_cnt[1] - a0 < 2) begin
      errors++;
      $display("FAIL reset_mid setup: got %0d W beats want 2", acc_cnt[1] - a0);
    end
    @(posedge clk);
    #2 areset_n = 1'b0;
    #1 check_all_zero("reset_mid");
    for (int c = 0; c < NCH; c++) begin
      q[c].delete();
      src[c].delete();
    end
    hold = '0;
    iv = '0;
    @(negedge clk);
    areset_n = 1'b1;
    #1;
    for (int c = 0; c < NCH; c++) begin
      checks++;
      if (irdy[c] !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid %s ready before edge: got %b want 0", nm[c], irdy[c]);
      end
    end
    set_all(0, 100);
    repeat (5) cycle();   // no stale beat may appear
  endtask

  initial begin
    for (int c = 0; c < NCH; c++) begin
      acc_cnt[c] = 0;
      dlv_cnt[c] = 0;
    end
    test_reset();
    test_single_write();
    test_back_to_back();
    test_stall();
    test_toggle_ready();
    test_concurrent();
    test_random();
    test_reset_mid();
    test_single_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
